// File: rtl/trace_fifo.sv
// Retirement trace FIFO: captures CPU writeback events into a first-word-fall-through
// queue, with a sticky overflow flag and a saturating drop counter.
module trace_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              debug_wb_pc,
    input  logic [3:0]               debug_wb_rf_we,
    input  logic [4:0]               debug_wb_rf_wnum,
    input  logic [31:0]              debug_wb_rf_wdata,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_pc,
    output logic [3:0]               trace_we,
    output logic [4:0]               trace_wnum,
    output logic [31:0]              trace_wdata,
    output logic [$clog2(DEPTH):0]   trace_count,
    input  logic                     ovf_clr,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 32 + 4 + 5 + 32;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          push, pop, full, accept, drop;
    logic [EW-1:0] wr_entry, head;

    assign wr_entry = {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata};
    assign push     = (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    assign pop      = trace_valid && trace_ready;
    assign full     = (count_q == CW'(DEPTH));
    assign accept   = push && (!full || pop);
    assign drop     = push && full && !pop;

    // Next-state for pointers, occupancy and overflow bookkeeping
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear wins: the clear is applied first
        if (drop) begin
            overflow_d = 1'b1;
            if (ovf_clr)                 drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage; contents are not cleared, reset only suppresses the write
    always_ff @(posedge clk) begin
        if (!reset && accept) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head        = mem_q[rd_ptr_q];
    assign trace_valid = (count_q != CW'(0));
    assign trace_pc    = trace_valid ? head[72:41] : 32'd0;
    assign trace_we    = trace_valid ? head[40:37] : 4'd0;
    assign trace_wnum  = trace_valid ? head[36:32] : 5'd0;
    assign trace_wdata = trace_valid ? head[31:0]  : 32'd0;
    assign trace_count = count_q;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_trace_fifo.sv
// Scoreboard bench for trace_fifo: stimulus queues expected entries, a negedge
// monitor compares the head against the queue and retires it on each handshake.
module tb_trace_fifo;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  we;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [3:0]  trace_we;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;
    logic [3:0]  trace_count;
    logic        ovf_clr;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int   tests  = 0;
    int   failed = 0;
    ent_t exp_q[$];

    trace_fifo #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_we(trace_we), .trace_wnum(trace_wnum),
        .trace_wdata(trace_wdata), .trace_count(trace_count),
        .ovf_clr(ovf_clr), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ent_t mk(input int i);
        ent_t e;
        e.pc    = 32'h1c00_0100 + 32'(i) * 32'd4;
        e.we    = 4'(1 + (i % 15));
        e.wnum  = 5'(1 + (i % 31));
        e.wdata = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
        return e;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one retirement for one edge; acc says whether the FIFO should keep it
    task automatic drive(input ent_t e, input logic rdy, input bit acc);
        debug_wb_pc       = e.pc;
        debug_wb_rf_we    = e.we;
        debug_wb_rf_wnum  = e.wnum;
        debug_wb_rf_wdata = e.wdata;
        trace_ready       = rdy;
        if (acc) exp_q.push_back(e);
        cycle();
        debug_wb_rf_we   = 4'd0;
        debug_wb_rf_wnum = 5'd0;
        ovf_clr          = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        trace_ready = rdy;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        trace_ready = 1'b1;
        while ((trace_count != 4'd0 || exp_q.size() != 0) && budget < 100) begin
            cycle();
            budget++;
        end
        trace_ready = 1'b0;
        chk("drain_count", 73'(trace_count), 73'd0);
        chk("drain_queue_empty", 73'(exp_q.size()), 73'd0);
    endtask

    // Monitor: head must match scoreboard front; zero fields when empty
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (trace_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 73'(trace_valid), 73'd0);
                end else begin
                    chk("head_entry", {trace_pc, trace_we, trace_wnum, trace_wdata}, exp_q[0]);
                    if (trace_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_fields_zero", {trace_pc, trace_we, trace_wnum, trace_wdata}, 73'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e;
        reset = 1'b1; trace_ready = 1'b0; ovf_clr = 1'b0;
        debug_wb_pc = '0; debug_wb_rf_we = '0; debug_wb_rf_wnum = '0; debug_wb_rf_wdata = '0;
        idle(2, 1'b0);
        reset = 1'b0;
        chk("reset_count", 73'(trace_count), 73'd0);
        chk("reset_valid", 73'(trace_valid), 73'd0);
        chk("reset_ovf", 73'(overflow), 73'd0);
        chk("reset_drop", 73'(drop_cnt), 73'd0);

        // Single capture held without ready
        e = '{pc: 32'h1c00_0000, we: 4'hF, wnum: 5'd4, wdata: 32'h1234_5678};
        drive(e, 1'b0, 1'b1);
        chk("single_valid", 73'(trace_valid), 73'd1);
        chk("single_count", 73'(trace_count), 73'd1);
        chk("single_pc", 73'(trace_pc), 73'h1c00_0000);
        idle(5, 1'b0);
        chk("hold_wdata", 73'(trace_wdata), 73'h1234_5678);
        drain();

        // r0 writes and no-enable cycles are ignored
        e = '{pc: 32'h1c00_0010, we: 4'hF, wnum: 5'd0, wdata: 32'hDEAD_BEEF};
        drive(e, 1'b0, 1'b0);
        e = '{pc: 32'h1c00_0014, we: 4'h0, wnum: 5'd5, wdata: 32'hCAFE_F00D};
        drive(e, 1'b0, 1'b0);
        chk("ignore_count", 73'(trace_count), 73'd0);
        chk("ignore_valid", 73'(trace_valid), 73'd0);

        // Ten pushes into an 8-deep FIFO: two drops
        for (int i = 0; i < 10; i++) drive(mk(i), 1'b0, i < 8);
        chk("ovf10_count", 73'(trace_count), 73'd8);
        chk("ovf10_flag", 73'(overflow), 73'd1);
        chk("ovf10_drops", 73'(drop_cnt), 73'd2);
        chk("ovf10_head_pc", 73'(trace_pc), 73'h1c00_0100);
        drain();
        ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
        chk("clr_flag", 73'(overflow), 73'd0);

        // Full FIFO with concurrent push/pop across pointer wrap
        for (int i = 20; i < 28; i++) drive(mk(i), 1'b0, 1'b1);
        for (int i = 28; i < 48; i++) begin
            drive(mk(i), 1'b1, 1'b1);
            chk("full_pp_count", 73'(trace_count), 73'd8);
            chk("full_pp_drop", 73'(drop_cnt), 73'd0);
        end
        drain();

        // Drop counter saturation and clear priority
        for (int i = 50; i < 58; i++) drive(mk(i), 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) drive(mk(100 + i), 1'b0, 1'b0);
        chk("sat_drops", 73'(drop_cnt), 73'd255);
        chk("sat_flag", 73'(overflow), 73'd1);
        ovf_clr = 1'b1;
        drive(mk(7), 1'b0, 1'b0);
        chk("clr_drop_flag", 73'(overflow), 73'd1);
        chk("clr_drop_cnt", 73'(drop_cnt), 73'd1);
        ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
        chk("clr_only_flag", 73'(overflow), 73'd0);
        chk("clr_only_cnt", 73'(drop_cnt), 73'd0);
        drain();

        // Push and ready together on an empty FIFO: push only
        drive(mk(60), 1'b1, 1'b1);
        chk("empty_pp_count", 73'(trace_count), 73'd1);
        chk("empty_pp_valid", 73'(trace_valid), 73'd1);
        drain();

        // Mid-operation reset with a concurrent push
        for (int i = 70; i < 79; i++) drive(mk(i), 1'b0, i < 78);
        idle(3, 1'b1);
        trace_ready = 1'b0;
        chk("pre_reset_count", 73'(trace_count), 73'd5);
        chk("pre_reset_ovf", 73'(overflow), 73'd1);
        reset = 1'b1;
        drive(mk(90), 1'b1, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        trace_ready = 1'b0;
        chk("rst_count", 73'(trace_count), 73'd0);
        chk("rst_valid", 73'(trace_valid), 73'd0);
        chk("rst_fields", {trace_pc, trace_we, trace_wnum, trace_wdata}, 73'd0);
        chk("rst_ovf", 73'(overflow), 73'd0);
        chk("rst_drop", 73'(drop_cnt), 73'd0);
        idle(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/trace_fifo.md
TRACE_FIFO -- requirements
Module: trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; legal values are powers of two from 2 to 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port debug_wb_pc  input  32  retiring instruction PC from the CPU writeback stage.
REQ-005 SHALL have port debug_wb_rf_we  input  4  retiring register-file byte write enables.
REQ-006 SHALL have port debug_wb_rf_wnum  input  5  retiring destination register number.
REQ-007 SHALL have port debug_wb_rf_wdata  input  32  retiring write data.
REQ-008 SHALL have port trace_valid  output  1  head entry available.
REQ-009 SHALL have port trace_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port trace_pc  output  32  head entry PC.
REQ-011 SHALL have port trace_we  output  4  head entry byte enables.
REQ-012 SHALL have port trace_wnum  output  5  head entry register number.
REQ-013 SHALL have port trace_wdata  output  32  head entry write data.
REQ-014 SHALL have port trace_count  output  log2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port ovf_clr  input  1  clears overflow and drop_cnt.
REQ-016 SHALL have port overflow  output  1  sticky flag: at least one capture was dropped.
REQ-017 SHALL have port drop_cnt  output  8  saturating count of dropped captures.

Function
REQ-018 SHALL capture (push) a retirement in any cycle where debug_wb_rf_we != 0 and debug_wb_rf_wnum != 0; writes to r0 and cycles with debug_wb_rf_we == 0 SHALL be ignored.
REQ-019 SHALL store {pc, we, wnum, wdata} of a pushed retirement; the entry is visible at the head no earlier than the cycle after the push (one-cycle push-to-valid latency).
REQ-020 SHALL present the oldest entry first-word-fall-through: trace_valid = (trace_count != 0), all four data fields driven from the head slot.
REQ-021 SHALL drive trace_pc, trace_we, trace_wnum and trace_wdata to 0 whenever trace_valid is 0.
REQ-022 SHALL pop the head entry in a cycle where trace_valid && trace_ready; trace_ready with trace_valid low SHALL have no effect.
REQ-023 SHALL keep head fields stable while trace_valid && !trace_ready.
REQ-024 SHALL implement read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-025 SHALL update trace_count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-026 SHALL, when full (count == DEPTH), accept a push in the same cycle as a pop (count stays DEPTH, no drop).
REQ-027 SHALL, when full and a push occurs without a pop, discard the new retirement, leave FIFO contents unchanged, set overflow and increment drop_cnt.
REQ-028 SHALL saturate drop_cnt at 255.
REQ-029 SHALL, on ovf_clr without a simultaneous drop, set overflow to 0 and drop_cnt to 0 in the next cycle.
REQ-030 SHALL, on ovf_clr coincident with a drop, give the drop priority: overflow = 1, drop_cnt = 1.
REQ-031 SHALL, on simultaneous push and pop when empty, push only (pop is not possible because trace_valid = 0) and raise trace_valid the next cycle.

Reset
REQ-032 SHALL, while reset is high at a clock edge, set both pointers to 0, trace_count to 0, overflow to 0 and drop_cnt to 0; trace_valid and all trace data outputs therefore read 0 in the following cycle.
REQ-033 SHALL discard all stored entries and any same-cycle push when reset is asserted mid-operation; storage array contents need not be cleared.
REQ-034 SHALL ignore debug_wb_* inputs, trace_ready and ovf_clr in any cycle with reset high.

Verification
REQ-035 SHALL pass: push pc=0x1c000000, we=0xF, wnum=4, wdata=0x12345678, trace_ready=0 -> next cycle trace_valid=1 with exactly those fields, count=1; hold 5 cycles -> fields stable.
REQ-036 SHALL pass: retirements with we=0xF/wnum=0, then we=0/wnum=5 -> count stays 0, trace_valid stays 0.
REQ-037 SHALL pass: DEPTH=8, trace_ready=0, 10 consecutive valid pushes -> count=8, overflow=1, drop_cnt=2, head=first pushed entry; then pop all 8 -> original order, count=0.
REQ-038 SHALL pass: full FIFO, push and pop in the same cycle, repeated 20 cycles -> count stays 8, no drop, output order matches input order across pointer wrap.
REQ-039 SHALL pass: drop_cnt driven to 255 by 300 drops -> remains 255; ovf_clr coincident with a drop -> overflow=1, drop_cnt=1; ovf_clr alone -> 0/0.
REQ-040 SHALL pass: count=5, assert reset 1 cycle with a concurrent push -> next cycle count=0, trace_valid=0, all trace fields 0, overflow=0.
